// File: rtl/bram_capture_pkg.sv
// Shared definitions for the BRAM capture/readout sequencer:
// FSM state encoding and the width rule for the captured-word counter.
package bram_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_READOUT = 2'd3
    } state_e;

    // The count must be able to hold 2**nb_addr, one more bit than an address
    function automatic int count_width(input int nb_addr);
        return nb_addr + 1;
    endfunction

endpackage

// File: rtl/bram_addr_cnt.sv
// Wrapping BRAM address pointer with clear, load and increment
// (priority in that order). Used for both the write and the read pointer.
module bram_addr_cnt
    import bram_capture_pkg::*;
#(
    parameter int NB_ADDR = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [NB_ADDR-1:0] load_val_i,
    input  logic               incr_i,
    output logic [NB_ADDR-1:0] addr_o
);

    logic [NB_ADDR-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (clear_i)
            addr_d = '0;
        else if (load_i)
            addr_d = load_val_i;
        else if (incr_i)
            addr_d = addr_q + NB_ADDR'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            addr_q <= '0;
        else
            addr_q <= addr_d;
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/bram_capture_ctrl.sv
// Capture/readout sequencer driving all BRAM control ports; readout accounts for
// the BRAM's one-cycle read latency. Define BRAM_CAPTURE_WRAP_EN for a circular buffer.
module bram_capture_ctrl
    import bram_capture_pkg::*;
#(
    parameter int NB_ADDR = 15,
    parameter int NB_DATA = 14
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_data_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_read,
    input  logic               i_ready,
    output logic               o_bram_write_enable,
    output logic [NB_ADDR-1:0] o_bram_write_addr,
    output logic [NB_DATA-1:0] o_bram_data,
    output logic               o_bram_read_enable,
    output logic [NB_ADDR-1:0] o_bram_read_addr,
    output logic               o_valid,
    output logic               o_last,
    output logic [NB_ADDR:0]   o_count,
    output logic [1:0]         o_state
);

    localparam int NB_CNT = count_width(NB_ADDR);
    localparam logic [NB_CNT-1:0] DEPTH = {1'b1, {NB_ADDR{1'b0}}};

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [NB_DATA-1:0] wdata_q, wdata_d;
    logic [NB_CNT-1:0]  count_q, count_d;
    logic [NB_CNT-1:0]  rd_cnt_q, rd_cnt_d;
    logic               valid_q, valid_d;

    logic [NB_ADDR-1:0] wptr, rptr, rd_start;
    logic [NB_CNT-1:0]  remaining;
    logic               accept, issue, full_exit, start_capture, start_read;

    // Write pointer and count advance on the registered write strobe, so the
    // pointer value is the address presented to the BRAM in that same cycle.
`ifdef BRAM_CAPTURE_WRAP_EN
    assign accept    = (state_q == ST_CAPTURE) && i_data_valid;
    assign full_exit = 1'b0;
    assign rd_start  = (count_q == DEPTH) ? wptr : '0;
`else
    logic [NB_CNT-1:0] count_ahead;
    assign count_ahead = count_q + NB_CNT'(we_q);
    assign accept    = (state_q == ST_CAPTURE) && i_data_valid && (count_ahead < DEPTH);
    assign full_exit = (count_q == DEPTH);
    assign rd_start  = '0;
`endif

    assign remaining = count_q - rd_cnt_q;
    assign issue     = (state_q == ST_READOUT) && (remaining != '0) && (!valid_q || i_ready);

    always_comb begin
        state_d       = state_q;
        start_capture = 1'b0;
        start_read    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d       = ST_CAPTURE;
                    start_capture = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (i_stop || full_exit)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_start) begin
                    state_d       = ST_CAPTURE;
                    start_capture = 1'b1;
                end else if (i_read && (count_q != '0) && !we_q) begin
                    state_d    = ST_READOUT;
                    start_read = 1'b1;
                end
            end
            ST_READOUT: begin
                if (valid_q && i_ready && (rd_cnt_q == count_q))
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_d     = accept;
        wdata_d  = accept ? i_data : wdata_q;
        count_d  = count_q;
        if (start_capture)
            count_d = '0;
        else if (we_q && (count_q != DEPTH))
            count_d = count_q + NB_CNT'(1);
        rd_cnt_d = start_read ? '0 : rd_cnt_q + NB_CNT'(issue);
        valid_d  = valid_q;
        if (issue)
            valid_d = 1'b1;
        else if (i_ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            count_q  <= '0;
            rd_cnt_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            rd_cnt_q <= rd_cnt_d;
            valid_q  <= valid_d;
        end
    end

    bram_addr_cnt #(.NB_ADDR(NB_ADDR)) u_wr_ptr (
        .clk_i      (clock),
        .rst_i      (i_reset),
        .clear_i    (start_capture),
        .load_i     (1'b0),
        .load_val_i ('0),
        .incr_i     (we_q),
        .addr_o     (wptr)
    );

    bram_addr_cnt #(.NB_ADDR(NB_ADDR)) u_rd_ptr (
        .clk_i      (clock),
        .rst_i      (i_reset),
        .clear_i    (1'b0),
        .load_i     (start_read),
        .load_val_i (rd_start),
        .incr_i     (issue),
        .addr_o     (rptr)
    );

    assign o_bram_write_enable = we_q;
    assign o_bram_write_addr   = wptr;
    assign o_bram_data         = wdata_q;
    assign o_bram_read_enable  = issue;
    assign o_bram_read_addr    = rptr;
    assign o_valid             = valid_q;
    assign o_last              = valid_q && (rd_cnt_q == count_q);
    assign o_count             = count_q;
    assign o_state             = state_q;

endmodule

// File: doc/bram_capture_ctrl.md
# bram_capture_ctrl

Capture/readout sequencer for the single-port-pair `bram` buffer in the RAM FSM design. It writes a burst of incoming samples into consecutive BRAM addresses, then streams them back out over a valid/ready interface while accounting for the BRAM's one-cycle read latency. It sits between the sample source, the `bram` instance and the downstream consumer, and owns every BRAM control port.

## Interface
- `NB_ADDR`, 15, BRAM address width; buffer depth is `2**NB_ADDR`.
- `NB_DATA`, 14, sample width.
- `clock` in 1: single system clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_start` in 1: start a capture; level, sampled in IDLE or DONE.
- `i_stop` in 1: end the capture early; sampled in CAPTURE.
- `i_data_valid` in 1: `i_data` carries a sample this cycle.
- `i_data` in NB_DATA: sample to capture.
- `i_read` in 1: start readout; sampled in DONE.
- `i_ready` in 1: consumer accepts the word on BRAM `o_data` this cycle.
- `o_bram_write_enable` out 1: to BRAM `i_write_enable`.
- `o_bram_write_addr` out NB_ADDR: to BRAM write address.
- `o_bram_data` out NB_DATA: to BRAM `i_data`.
- `o_bram_read_enable` out 1: to BRAM `i_read_enable`.
- `o_bram_read_addr` out NB_ADDR: to BRAM `i_read_addr`.
- `o_valid` out 1: BRAM `o_data` holds a valid readout word.
- `o_last` out 1: the current valid word is the final one.
- `o_count` out NB_ADDR+1: number of words captured.
- `o_state` out 2: current FSM state, for debug.

## Operation
- States: IDLE=0, CAPTURE=1, DONE=2, READOUT=3.
- IDLE: `i_start` clears `o_count` and the write pointer, then moves to CAPTURE.
- CAPTURE: each `i_data_valid` cycle writes `i_data` to the write pointer, increments the pointer, and increments `o_count`.
- CAPTURE exits to DONE on `i_stop`, or when `o_count` reaches `2**NB_ADDR` (see Configuration).
- A sample arriving together with `i_stop` is still written.
- DONE: `i_start` re-enters CAPTURE and overwrites the buffer. `i_read` enters READOUT with the read pointer at the start address. `i_start` wins if both are asserted.
- DONE with `o_count`=0: `i_read` is ignored.
- READOUT issue rule: `issue = (remaining > 0) && (!o_valid || i_ready)`. `o_bram_read_enable = issue` (combinational); the read pointer increments on issue.
- `o_valid` next value: 1 on issue; otherwise 0 if `i_ready`; otherwise hold.
- While `o_valid` is high and `i_ready` is low, the BRAM holds `o_data` because read enable stays low.
- `o_last` = `o_valid` and the word is number `o_count`.
- Accepting the last word returns the FSM to DONE, so the same data can be read out again.
- Pointers are NB_ADDR bits wide and wrap modulo `2**NB_ADDR`. `o_count` saturates at `2**NB_ADDR`.
- Reset mid-operation: return to IDLE immediately. Partially written BRAM contents are left untouched.

## Timing
- Reset values: state IDLE. `o_bram_write_enable`, `o_bram_read_enable`, `o_valid` and `o_last` are 0. Addresses, `o_bram_data` and `o_count` are 0.
- Write path is registered: a sample accepted at edge N drives the write ports in cycle N+1 and lands in the BRAM at edge N+2.
- `o_count` updates at edge N+1.
- Read path: read issued in cycle N, data valid on BRAM `o_data` with `o_valid`=1 in cycle N+1.
- With `i_ready` held high, throughput is one word per cycle.
- READOUT is entered no earlier than 2 cycles after the last capture write, so there is no read-during-write hazard.

## Configuration
- `BRAM_CAPTURE_WRAP_EN` defined: the buffer is circular.
  - CAPTURE ignores the full condition and ends only on `i_stop`.
  - The write pointer wraps; `o_count` saturates at `2**NB_ADDR`.
  - If a wrap occurred, readout starts at the write pointer (oldest word); otherwise it starts at 0.
- Not defined:
  - Reaching `2**NB_ADDR` words forces DONE.
  - Samples arriving after that are dropped.
  - Readout always starts at 0.

## Structure
- Shared package `bram_capture_pkg`: state encoding constants (IDLE/CAPTURE/DONE/READOUT) and the `o_count` width rule (NB_ADDR+1).
- One sub-module, `bram_addr_cnt`: a wrapping NB_ADDR pointer with clear, load and increment. Instantiate it twice, once for write and once for read.
- The `bram` instance lives in the parent, not inside this block.

## Test plan
Bench uses NB_ADDR=3 and NB_DATA=8.
- Reset check: assert `i_reset` mid-CAPTURE -> next cycle all outputs are 0 and `o_state`=0.
- Capture and readout: capture 5 samples 0x11..0x15, then `i_stop`, then `i_read` with `i_ready`=1 -> `o_count`=5; readout gives 0x11..0x15 on 5 consecutive cycles, `o_last` only on 0x15, state returns to DONE.
- Backpressure: during readout, `i_ready` pattern 1,0,0,1,1 -> no word is lost or duplicated, `o_data` is stable while stalled, and BRAM read enable is low during the stall.
- Full buffer: without the macro, feed 10 samples -> 8 written, `o_count`=8, DONE entered automatically, samples 9 and 10 not written.
- Wrap: with `BRAM_CAPTURE_WRAP_EN`, feed 10 samples 0..9 then `i_stop` -> readout gives 2..9, `o_count`=8.
- Edge cases: `i_start` in DONE -> `o_count` clears and the buffer is overwritten. `i_read` with `o_count`=0 -> stays in DONE, `o_valid` stays low.
